nadajnik: RTL

UART transmitter, 8N1 format: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity. It is the transmit-side counterpart of the team's UART receiver and uses the same bit timing, so the two blocks can be looped back to each other. It accepts one byte per start strobe, serialises it on TXD_o and reports busy and done status to the host logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/licznik_baud.sv | 36 +++
 rtl/nadajnik.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Purpose: constants and state encoding shared by the UART transmitter and
//          receiver so that both ends agree on bit timing and frame layout.
// Contents: uart_state_e (IDLE/START/DATA/STOP/CLEANUP), default bit period,
//           data width and idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

  // 100 MHz system clock at 9600 baud
  localparam int  CLKS_PER_BIT_DEF = 10416;
  localparam int  UART_DATA_BITS   = 8;
  localparam logic LINE_IDLE       = 1'b1;

endpackage

// File: rtl/licznik_baud.sv
// Purpose: modulo-CLKS_PER_BIT counter marking UART bit boundaries.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   clr_i   restart the count at 0 (wins over en_i)
//   en_i    advance the count
//   tick_o  high while enabled and the count is CLKS_PER_BIT-1 (last cycle of a bit)
module licznik_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            W    = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (en_i)   cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nadajnik.sv
// Purpose: UART 8N1 transmitter (start bit, 8 data bits LSB-first, stop bit).
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset; aborts any frame in flight
//   tx_start_i   send request, level-sampled in IDLE only
//   txData_i     byte to send, captured on the accept edge
//   TXD_o        registered serial line, idle high
//   txBUSY_o     high from the first start-bit cycle through CLEANUP
//   txWYSLANE_o  single-cycle pulse in CLEANUP when the frame is complete
//
// state   | meaning
// IDLE    | line high, waiting for tx_start_i
// START   | driving the start bit (low) for one bit period
// DATA    | driving data bit bit_idx_q for one bit period each
// STOP    | driving the stop bit (high) for one bit period
// CLEANUP | one cycle, done pulse, then back to IDLE
module nadajnik
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_start_i,
  input  logic [DATA_BITS-1:0] txData_i,
  output logic                 TXD_o,
  output logic                 txBUSY_o,
  output logic                 txWYSLANE_o
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 txd_q, busy_q, done_q;

  logic accept, baud_en, tick;

  assign accept  = (state_q == IDLE) && tx_start_i;
  assign baud_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  licznik_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (accept),
    .en_i   (baud_en),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q  <= LINE_IDLE;
          busy_q <= 1'b0;
          if (tx_start_i) begin
            shift_q   <= txData_i;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick) begin
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          // shift_q[0] is the bit on the line; the next one sits at [1]
          if (tick) begin
            if (bit_idx_q == LAST_BIT) begin
              txd_q   <= LINE_IDLE;
              state_q <= STOP;
            end else begin
              txd_q     <= shift_q[1];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            done_q  <= 1'b1;
            state_q <= CLEANUP;
          end
        end
        CLEANUP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TXD_o       = txd_q;
  assign txBUSY_o    = busy_q;
  assign txWYSLANE_o = done_q;

endmodule
